// File: rtl/fix_pkg.sv
// ---------------------------------------------------------------------------
// fix_pkg
// Shared definitions for the FIX message framer: the framer FSM state
// encoding, the ASCII byte constants the framer recognises, the error-code
// encoding reported on err_code_o, and a digit-classification helper.
//
// Optional feature macro (consumed by fix_framer): FIX_FRAMER_TIMEOUT_EN.
// ---------------------------------------------------------------------------
package fix_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    HDR      = 4'd1,
    BODY     = 4'd2,
    SOH_SEEN = 4'd3,
    TAG1     = 4'd4,
    TAG0     = 4'd5,
    DIG0     = 4'd6,
    DIG1     = 4'd7,
    DIG2     = 4'd8,
    TERM     = 4'd9
  } fix_state_e;

  typedef enum logic [1:0] {
    ERR_CHK = 2'd0,
    ERR_FMT = 2'd1,
    ERR_LEN = 2'd2,
    ERR_TMO = 2'd3
  } fix_err_e;

  localparam logic [7:0] ASC_SOH = 8'h01;
  localparam logic [7:0] ASC_8   = 8'h38;
  localparam logic [7:0] ASC_EQ  = 8'h3D;
  localparam logic [7:0] ASC_0   = 8'h30;
  localparam logic [7:0] ASC_1   = 8'h31;

  // '8' + '=' : the header bytes are folded into the sum when BODY is entered.
  localparam logic [7:0] HDR_SEED = 8'h75;
  // '1' + '0' + '=' : the trailer tag bytes, removed again once recognised.
  localparam logic [7:0] TAG_SUM  = 8'h9E;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= ASC_0) && (b <= (ASC_0 + 8'd9));
  endfunction

endpackage

// File: rtl/fix_ascii_dec.sv
// ---------------------------------------------------------------------------
// fix_ascii_dec
// Accumulates the three ASCII digits of the checksum trailer into a decimal
// value (0..999) and flags bytes that are not ASCII digits.
//
// Ports:
//   clk      in   1   clock, posedge
//   rst      in   1   synchronous active-high reset
//   clr      in   1   clear the accumulator (start of a new trailer)
//   en       in   1   accept data_i as the next digit
//   data_i   in   8   candidate digit byte
//   value_o  out  10  accumulated decimal value
//   bad_o    out  1   data_i is not an ASCII digit (combinational)
// ---------------------------------------------------------------------------
module fix_ascii_dec
  import fix_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] data_i,
  output logic [9:0] value_o,
  output logic       bad_o
);

  logic [9:0] acc;

  always_comb begin
    bad_o = !is_digit(data_i);
    // At most two digits are held when the third arrives, so 99*10+9 fits.
    acc   = (value_o * 10'd10) + {6'd0, data_i[3:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_o <= '0;
    end else if (clr) begin
      value_o <= '0;
    end else if (en) begin
      value_o <= acc;
    end
  end

endmodule

// File: rtl/fix_framer.sv
// ---------------------------------------------------------------------------
// fix_framer
// Frames FIX messages from a byte stream: finds the "8=" header, runs the
// mod-256 checksum over the message, locates the "<SOH>10=ddd<SOH>" trailer,
// decodes the received checksum and reports completion or errors.
//
// Parameters:
//   MAX_LEN         max bytes per message, "8=" through trailer SOH
//   TIMEOUT_CYCLES  max consecutive idle cycles mid-message (timeout build)
//
// Ports:
//   clk         in   1   clock, posedge
//   rst         in   1   synchronous active-high reset
//   data_i      in   8   received byte
//   valid_i     in   1   data_i valid
//   data_o      out  8   registered data_i
//   valid_o     out  1   registered valid_i
//   start_o     out  1   with the '=' of the "8=" header on data_o
//   end_o       out  1   with the trailer-terminating SOH on data_o
//   rx_chk_o    out  10  decoded trailer value, held until next start_o
//   calc_chk_o  out  8   computed checksum, held until next start_o
//   done_o      out  1   message complete (cycle after end_o)
//   chk_ok_o    out  1   with done_o: received checksum matches
//   err_o       out  1   abort or checksum mismatch
//   err_code_o  out  2   0 mismatch, 1 format, 2 length, 3 timeout
//
// Build option: define FIX_FRAMER_TIMEOUT_EN to enable the stall timeout.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | hunting for '8'
// HDR      | '8' seen, expecting '='
// BODY     | inside message body, summing
// SOH_SEEN | SOH seen, possible start of "10="
// TAG1     | "<SOH>1" seen
// TAG0     | "<SOH>10" seen
// DIG0     | expecting hundreds digit
// DIG1     | expecting tens digit
// DIG2     | expecting units digit
// TERM     | expecting terminating SOH
// ---------------------------------------------------------------------------
module fix_framer
  import fix_pkg::*;
#(
  parameter int unsigned MAX_LEN        = 2048,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       start_o,
  output logic       end_o,
  output logic [9:0] rx_chk_o,
  output logic [7:0] calc_chk_o,
  output logic       done_o,
  output logic       chk_ok_o,
  output logic       err_o,
  output logic [1:0] err_code_o
);

  localparam int unsigned     LEN_W   = $clog2(MAX_LEN + 2);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

  // The shortest legal message "8=<SOH>10=ddd<SOH>" is 10 bytes.
  if (MAX_LEN < 10 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("fix_framer: MAX_LEN must be >= 10 and TIMEOUT_CYCLES >= 1");
  end

  fix_state_e       state, state_nxt;
  logic [7:0]       sum, sum_nxt, sum_add;
  logic [LEN_W-1:0] len_cnt, len_nxt, len_inc;
  logic             start_nxt, end_nxt;
  logic             calc_load, rx_load;
  logic             dec_clr, dec_en, dec_bad;
  logic [9:0]       dec_value;
  logic             abort;
  fix_err_e         abort_code;
  logic             tmo_expire;
  logic             chk_match;

  fix_ascii_dec u_dec (
    .clk     (clk),
    .rst     (rst),
    .clr     (dec_clr),
    .en      (dec_en),
    .data_i  (data_i),
    .value_o (dec_value),
    .bad_o   (dec_bad)
  );

`ifdef FIX_FRAMER_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  // Down-counter of idle cycles still tolerated; expiry on the last one.
  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_expire = !valid_i && (state != IDLE) && (tmo_cnt == TMO_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (valid_i || (state == IDLE) || tmo_expire) begin
      tmo_cnt <= TMO_W'(TIMEOUT_CYCLES);
    end else if (tmo_cnt != '0) begin
      tmo_cnt <= tmo_cnt - TMO_W'(1);
    end
  end
`else
  assign tmo_expire = 1'b0;
`endif

  // Values above 255 can never match an 8-bit sum.
  assign chk_match = (rx_chk_o[9:8] == 2'b00) && (rx_chk_o[7:0] == calc_chk_o);

  always_comb begin
    state_nxt  = state;
    sum_nxt    = sum;
    len_nxt    = len_cnt;
    start_nxt  = 1'b0;
    end_nxt    = 1'b0;
    calc_load  = 1'b0;
    rx_load    = 1'b0;
    dec_clr    = 1'b0;
    dec_en     = 1'b0;
    abort      = 1'b0;
    abort_code = ERR_FMT;
    len_inc    = len_cnt + LEN_W'(1);
    sum_add    = sum + data_i;

    if (valid_i) begin
      unique case (state)
        IDLE: begin
          if (data_i == ASC_8) state_nxt = HDR;
        end
        HDR: begin
          if (data_i == ASC_EQ) begin
            state_nxt = BODY;
            sum_nxt   = HDR_SEED;
            len_nxt   = LEN_W'(2);
            start_nxt = 1'b1;
          end else if (data_i != ASC_8) begin
            state_nxt = IDLE;
          end
        end
        default: begin
          // Every byte after the header counts toward the length,
          // trailer included.
          if (len_inc > LEN_MAX) begin
            abort      = 1'b1;
            abort_code = ERR_LEN;
          end else begin
            len_nxt = len_inc;
            case (state)
              BODY, SOH_SEEN, TAG1, TAG0: begin
                sum_nxt = sum_add;
                if (data_i == ASC_SOH) begin
                  state_nxt = SOH_SEEN;
                end else if (state == SOH_SEEN && data_i == ASC_1) begin
                  state_nxt = TAG1;
                end else if (state == TAG1 && data_i == ASC_0) begin
                  state_nxt = TAG0;
                end else if (state == TAG0 && data_i == ASC_EQ) begin
                  // "10=" was summed on the way in; take it back out.
                  state_nxt = DIG0;
                  sum_nxt   = sum_add - TAG_SUM;
                  calc_load = 1'b1;
                  dec_clr   = 1'b1;
                end else begin
                  state_nxt = BODY;
                end
              end
              DIG0, DIG1, DIG2: begin
                if (dec_bad) begin
                  abort = 1'b1;
                end else begin
                  dec_en    = 1'b1;
                  state_nxt = (state == DIG0) ? DIG1 :
                              (state == DIG1) ? DIG2 : TERM;
                end
              end
              TERM: begin
                if (data_i == ASC_SOH) begin
                  end_nxt   = 1'b1;
                  rx_load   = 1'b1;
                  state_nxt = IDLE;
                end else begin
                  abort = 1'b1;
                end
              end
              default: state_nxt = IDLE;
            endcase
          end
        end
      endcase
    end else if (tmo_expire) begin
      abort      = 1'b1;
      abort_code = ERR_TMO;
    end

    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sum        <= '0;
      len_cnt    <= '0;
      data_o     <= '0;
      valid_o    <= 1'b0;
      start_o    <= 1'b0;
      end_o      <= 1'b0;
      rx_chk_o   <= '0;
      calc_chk_o <= '0;
      done_o     <= 1'b0;
      chk_ok_o   <= 1'b0;
      err_o      <= 1'b0;
      err_code_o <= '0;
    end else begin
      state   <= state_nxt;
      sum     <= sum_nxt;
      len_cnt <= len_nxt;
      data_o  <= data_i;
      valid_o <= valid_i;
      start_o <= start_nxt;
      end_o   <= end_nxt;

      if (start_nxt) begin
        rx_chk_o   <= '0;
        calc_chk_o <= '0;
      end
      if (calc_load) calc_chk_o <= sum_nxt;
      if (rx_load)   rx_chk_o   <= dec_value;

      // Completion is judged the cycle after end_o, once rx_chk_o is loaded.
      // The byte after a terminating SOH is seen in IDLE and cannot abort,
      // so a mismatch report never collides with an abort.
      done_o     <= end_o;
      chk_ok_o   <= end_o && chk_match;
      err_o      <= abort || (end_o && !chk_match);
      err_code_o <= abort ? abort_code : ERR_CHK;
    end
  end

endmodule

// File: tb/tb_fix_framer.sv
module tb_fix_framer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_i;
  logic       valid_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       start_o;
  logic       end_o;
  logic [9:0] rx_chk_o;
  logic [7:0] calc_chk_o;
  logic       done_o;
  logic       chk_ok_o;
  logic       err_o;
  logic [1:0] err_code_o;

  always #5 clk = ~clk;

  fix_framer #(.MAX_LEN(16), .TIMEOUT_CYCLES(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .start_o    (start_o),
    .end_o      (end_o),
    .rx_chk_o   (rx_chk_o),
    .calc_chk_o (calc_chk_o),
    .done_o     (done_o),
    .chk_ok_o   (chk_ok_o),
    .err_o      (err_o),
    .err_code_o (err_code_o)
  );

  // Expected completion/error event for one message.
  typedef struct packed {
    bit  stall;
    int  gap;
    bit  done;
    bit  ok;
    bit  err;
    int  code;
    int  calc;
    int  rx;
    bit  bchk;
    int  ebyte;
  } vec_t;

  vec_t       vec_q[$];
  string      msg_q[$];
  vec_t       ev_q[$];
  logic [7:0] byte_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  bit prev_end = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  function automatic void add(input string m, input bit stall, input int gap,
                              input bit done, input bit ok, input bit err,
                              input int code, input int calc, input int rx,
                              input bit bchk, input int eb);
    vec_t v;
    v.stall = stall; v.gap = gap; v.done = done; v.ok = ok; v.err = err;
    v.code = code; v.calc = calc; v.rx = rx; v.bchk = bchk; v.ebyte = eb;
    vec_q.push_back(v);
    msg_q.push_back(m);
  endfunction

  function automatic vec_t ev(input bit done, input bit ok, input bit err,
                              input int code, input int calc, input int rx);
    vec_t v;
    v = '0;
    v.done = done; v.ok = ok; v.err = err; v.code = code;
    v.calc = calc; v.rx = rx;
    return v;
  endfunction

  // '|' in message text stands for SOH.
  task automatic send(input string m, input bit stall);
    logic [7:0] b;
    for (int i = 0; i < m.len(); i++) begin
      b = m[i];
      if (b == 8'h7C) b = 8'h01;
      data_i  = b;
      valid_i = 1'b1;
      byte_q.push_back(b);
      @(negedge clk);
      if (stall) begin
        valid_i = 1'b0;
        @(negedge clk);
      end
    end
    valid_i = 1'b0;
    data_i  = 8'h00;
  endtask

  task automatic idle(input int n);
    valid_i = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((ev_q.size() != 0 || byte_q.size() != 0) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", ev_q.size() + byte_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // Monitor / scoreboard: sampled on the falling edge.
  always @(negedge clk) begin
    vec_t e;
    if (rst) begin
      prev_end = 1'b0;
    end else begin
      if (valid_o) begin
        if (byte_q.size() == 0) chk("unexpected_valid_o", 1, 0);
        else chk("data_o", int'(data_o), int'(byte_q.pop_front()));
      end
      if (start_o) chk("start_byte", int'(data_o), 8'h3D);
      if (end_o)   chk("end_byte", int'(data_o), 8'h01);
      if (chk_ok_o && !done_o) chk("chk_ok_without_done", 1, 0);
      if (done_o || err_o) begin
        if (ev_q.size() == 0) begin
          chk("unexpected_event", int'({done_o, err_o}), 0);
        end else begin
          e = ev_q.pop_front();
          chk("done", int'(done_o), int'(e.done));
          chk("err", int'(err_o), int'(e.err));
          if (e.err)  chk("err_code", int'(err_code_o), e.code);
          if (e.done) begin
            chk("chk_ok", int'(chk_ok_o), int'(e.ok));
            chk("calc_chk", int'(calc_chk_o), e.calc);
            chk("rx_chk", int'(rx_chk_o), e.rx);
            chk("done_after_end", int'(prev_end), 1);
          end
          if (e.bchk) chk("err_byte", int'(data_o), e.ebyte);
        end
      end
      prev_end = end_o;
    end
  end

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_data_o"},     int'(data_o), 0);
    chk({tag, "_valid_o"},    int'(valid_o), 0);
    chk({tag, "_start_o"},    int'(start_o), 0);
    chk({tag, "_end_o"},      int'(end_o), 0);
    chk({tag, "_rx_chk_o"},   int'(rx_chk_o), 0);
    chk({tag, "_calc_chk_o"}, int'(calc_chk_o), 0);
    chk({tag, "_done_o"},     int'(done_o), 0);
    chk({tag, "_chk_ok_o"},   int'(chk_ok_o), 0);
    chk({tag, "_err_o"},      int'(err_o), 0);
    chk({tag, "_err_code_o"}, int'(err_code_o), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    valid_i = 1'b0;
    data_i  = 8'h00;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    //   msg                      stl gap dn ok er cd calc  rx bchk byte
    add("8=A|10=183|",             0, 3, 1, 1, 0, 0, 183, 183, 0, 0);
    add("8=A|10=184|",             1, 3, 1, 0, 1, 0, 183, 184, 0, 0);
    add("8=A|10=1X3|",             0, 3, 0, 0, 1, 1,   0,   0, 1, 8'h58);
    add("8=A|10=300|",             0, 0, 1, 0, 1, 0, 183, 300, 0, 0);
    add("8=A|10=300|",             0, 3, 1, 0, 1, 0, 183, 300, 0, 0);
    add("8=A|10=439|",             0, 3, 1, 0, 1, 0, 183, 439, 0, 0);
    add("8=A|10=999|",             0, 3, 1, 0, 1, 0, 183, 999, 0, 0);
    add("8=A|10=183X",             0, 3, 0, 0, 1, 1,   0,   0, 1, 8'h58);
    add("8=A|10=/83|",             0, 3, 0, 0, 1, 1,   0,   0, 1, 8'h2F);
    add("8=A|10=18:|",             0, 3, 0, 0, 1, 1,   0,   0, 1, 8'h3A);
    add("8=B|1|10=234|",           1, 3, 1, 1, 0, 0, 234, 234, 0, 0);
    add("Q88=A|10=183|",           0, 3, 1, 1, 0, 0, 183, 183, 0, 0);
    add("8=BBBBBB|10=002|",        0, 3, 1, 1, 0, 0,   2,   2, 0, 0);
    add("8=BBBBBBB|10=068|",       0, 3, 0, 0, 1, 2,   0,   0, 1, 8'h01);
    add("8=BBBBBBBBBBBBBBBBBBBB",  0, 3, 0, 0, 1, 2,   0,   0, 1, 8'h42);

    for (int i = 0; i < vec_q.size(); i++) begin
      ev_q.push_back(vec_q[i]);
      send(msg_q[i], vec_q[i].stall);
      idle(vec_q[i].gap);
    end
    drain();

    // Results stay held after completion.
    ev_q.push_back(ev(1, 0, 1, 0, 183, 184));
    send("8=A|10=184|", 0);
    drain();
    repeat (4) @(negedge clk);
    chk("hold_calc_chk", int'(calc_chk_o), 183);
    chk("hold_rx_chk", int'(rx_chk_o), 184);

    // Reset in the middle of the trailer discards the message.
    send("8=A|10=18", 0);
    rst = 1'b1;
    byte_q.delete();
    repeat (2) @(negedge clk);
    check_zero_outputs("midrst");
    rst = 1'b0;
    @(negedge clk);
    ev_q.push_back(ev(1, 1, 0, 0, 183, 183));
    send("8=A|10=183|", 0);
    drain();

    // Stall one cycle short of the timeout: message still completes.
    ev_q.push_back(ev(1, 1, 0, 0, 183, 183));
    send("8=A", 0);
    idle(7);
    send("|10=183|", 0);
    drain();

`ifdef FIX_FRAMER_TIMEOUT_EN
    ev_q.push_back(ev(0, 0, 1, 3, 0, 0));
    send("8=A", 0);
    idle(8);
    drain();
`else
    ev_q.push_back(ev(1, 1, 0, 0, 183, 183));
    send("8=A", 0);
    idle(20);
    send("|10=183|", 0);
    drain();
`endif

    // Framer back in IDLE after the above: a fresh message still passes.
    ev_q.push_back(ev(1, 1, 0, 0, 183, 183));
    send("8=A|10=183|", 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
